// File: rtl/wb_regfile_pkg.sv
// ---------------------------------------------------------------------------
// wb_regfile_pkg
//   Shared definitions for the writeback stage and the integer register file.
//   Holds the architectural widths, the hardwired-zero register index and the
//   common word / register-address types.
//   Ports: none (package).
// ---------------------------------------------------------------------------
package wb_regfile_pkg;

  // Architectural data width and register file geometry.
  localparam int XLEN       = 32;
  localparam int NUM_REGS   = 32;
  localparam int REG_ADDR_W = 5;
  localparam int CNT_W      = 64;

  typedef logic [XLEN-1:0]       word_t;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  // x0 is the architectural constant-zero register.
  localparam reg_addr_t REG_ZERO = 5'd0;

endpackage : wb_regfile_pkg

// File: rtl/wb_regfile_array.sv
// ---------------------------------------------------------------------------
// wb_regfile_array
//   Storage for the integer register file: one synchronous write port and two
//   asynchronous read ports. Entry 0 is never written and always reads zero.
//   The whole array clears on the asynchronous active-low reset.
//   Ports:
//     clk      in   1       write clock
//     rst_n    in   1       asynchronous active-low clear of every entry
//     we       in   1       write strobe (writes to entry 0 are ignored)
//     waddr    in   ADDR_W  write address
//     wdata    in   XLEN    write data
//     raddr1   in   ADDR_W  read port 1 address
//     raddr2   in   ADDR_W  read port 2 address
//     rdata1   out  XLEN    read port 1 data (combinational)
//     rdata2   out  XLEN    read port 2 data (combinational)
// ---------------------------------------------------------------------------
module wb_regfile_array #(
  parameter int XLEN   = wb_regfile_pkg::XLEN,
  parameter int NREGS  = wb_regfile_pkg::NUM_REGS,
  parameter int ADDR_W = wb_regfile_pkg::REG_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [XLEN-1:0]   wdata,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [XLEN-1:0]   rdata1,
  output logic [XLEN-1:0]   rdata2
);

  import wb_regfile_pkg::*;

  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];

  // Next-state of the array. Entry 0 is pinned to zero so no write, however
  // presented, can ever make x0 non-zero.
  always_comb begin
    regs_d = regs_q;
    if (we && (waddr != ADDR_W'(REG_ZERO))) begin
      regs_d[waddr] = wdata;
    end
    regs_d[0] = '0;
  end

  // Reset clears every entry, so no uninitialised value can ever be read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Address 0 is decoded explicitly on the read side as well.
  always_comb begin
    rdata1 = regs_q[raddr1];
    rdata2 = regs_q[raddr2];
    if (raddr1 == ADDR_W'(REG_ZERO)) begin
      rdata1 = '0;
    end
    if (raddr2 == ADDR_W'(REG_ZERO)) begin
      rdata2 = '0;
    end
  end

endmodule : wb_regfile_array

// File: rtl/wb_regfile.sv
// ---------------------------------------------------------------------------
// wb_regfile
//   Writeback stage and architectural register file (consumer end of the
//   MEM/WB pipeline register). Selects load data or ALU result, commits it to
//   the 32-entry register file, serves the two ID-stage read ports with a
//   same-cycle write-through bypass, and counts committed writes.
//   Ports:
//     clk            in   1       single clock, posedge
//     rst_n          in   1       asynchronous active-low reset
//     wb_regwrite    in   1       commit request from MEM/WB
//     wb_memtoreg    in   1       1 = load data, 0 = ALU result
//     wb_read_data   in   XLEN    data-memory load result
//     wb_alu_result  in   XLEN    ALU result
//     wb_rd_addr     in   ADDR_W  destination register
//     id_rs1_addr    in   ADDR_W  read port 1 address
//     id_rs2_addr    in   ADDR_W  read port 2 address
//     id_rs1_data    out  XLEN    read port 1 data (combinational)
//     id_rs2_data    out  XLEN    read port 2 data (combinational)
//     wb_write_data  out  XLEN    selected writeback value (combinational)
//     wb_write_en    out  1       qualified commit strobe (never for x0)
//     commit_count   out  CNT_W   committed writes since reset (wraps)
// ---------------------------------------------------------------------------
module wb_regfile #(
  parameter int XLEN   = wb_regfile_pkg::XLEN,
  parameter int NREGS  = wb_regfile_pkg::NUM_REGS,
  parameter int ADDR_W = wb_regfile_pkg::REG_ADDR_W,
  parameter int CNT_W  = wb_regfile_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_regwrite,
  input  logic              wb_memtoreg,
  input  logic [XLEN-1:0]   wb_read_data,
  input  logic [XLEN-1:0]   wb_alu_result,
  input  logic [ADDR_W-1:0] wb_rd_addr,
  input  logic [ADDR_W-1:0] id_rs1_addr,
  input  logic [ADDR_W-1:0] id_rs2_addr,
  output logic [XLEN-1:0]   id_rs1_data,
  output logic [XLEN-1:0]   id_rs2_data,
  output logic [XLEN-1:0]   wb_write_data,
  output logic              wb_write_en,
  output logic [CNT_W-1:0]  commit_count
);

  import wb_regfile_pkg::*;

  logic [XLEN-1:0]  arr_rdata1;
  logic [XLEN-1:0]  arr_rdata2;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Writeback mux and qualified commit strobe. A write aimed at x0 is not a
  // commit: it neither reaches the array nor advances the counter.
  always_comb begin
    wb_write_data = wb_memtoreg ? wb_read_data : wb_alu_result;
    wb_write_en   = wb_regwrite && (wb_rd_addr != ADDR_W'(REG_ZERO));
  end

  wb_regfile_array #(
    .XLEN   (XLEN),
    .NREGS  (NREGS),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (wb_write_en),
    .waddr  (wb_rd_addr),
    .wdata  (wb_write_data),
    .raddr1 (id_rs1_addr),
    .raddr2 (id_rs2_addr),
    .rdata1 (arr_rdata1),
    .rdata2 (arr_rdata2)
  );

  // Read ports with write-through bypass so an instruction in ID sees the
  // value being committed this cycle without a stall. Zero check comes
  // first; the bypass is keyed on the qualified strobe so a non-committing
  // writeback never leaks into a read.
  always_comb begin
    if (id_rs1_addr == ADDR_W'(REG_ZERO)) begin
      id_rs1_data = '0;
    end else if (wb_write_en && (id_rs1_addr == wb_rd_addr)) begin
      id_rs1_data = wb_write_data;
    end else begin
      id_rs1_data = arr_rdata1;
    end

    if (id_rs2_addr == ADDR_W'(REG_ZERO)) begin
      id_rs2_data = '0;
    end else if (wb_write_en && (id_rs2_addr == wb_rd_addr)) begin
      id_rs2_data = wb_write_data;
    end else begin
      id_rs2_data = arr_rdata2;
    end
  end

  // Committed-write counter; wraps naturally at the top of its range.
  always_comb begin
    count_d = count_q;
    if (wb_write_en) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign commit_count = count_q;

endmodule : wb_regfile

// File: tb/tb_wb_regfile.sv
// ---------------------------------------------------------------------------
// tb_wb_regfile
//   Directed self-checking bench for wb_regfile. A second instance with a
//   4-bit commit counter exercises counter wrap-around in a few cycles.
// ---------------------------------------------------------------------------
module tb_wb_regfile;

  logic        clk;
  logic        rst_n;

  logic        regwrite;
  logic        memtoreg;
  logic [31:0] read_data;
  logic [31:0] alu_result;
  logic [4:0]  rd_addr;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [31:0] write_data;
  logic        write_en;
  logic [63:0] commit_count;

  logic        w_regwrite;
  logic        w_memtoreg;
  logic [31:0] w_read_data;
  logic [31:0] w_alu_result;
  logic [4:0]  w_rd_addr;
  logic [4:0]  w_rs1_addr;
  logic [4:0]  w_rs2_addr;
  logic [31:0] w_rs1_data;
  logic [31:0] w_rs2_data;
  logic [31:0] w_write_data;
  logic        w_write_en;
  logic [3:0]  w_count;

  int n_cmp;
  int n_fail;

  wb_regfile dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .wb_regwrite   (regwrite),
    .wb_memtoreg   (memtoreg),
    .wb_read_data  (read_data),
    .wb_alu_result (alu_result),
    .wb_rd_addr    (rd_addr),
    .id_rs1_addr   (rs1_addr),
    .id_rs2_addr   (rs2_addr),
    .id_rs1_data   (rs1_data),
    .id_rs2_data   (rs2_data),
    .wb_write_data (write_data),
    .wb_write_en   (write_en),
    .commit_count  (commit_count)
  );

  wb_regfile #(.CNT_W(4)) dut_wrap (
    .clk           (clk),
    .rst_n         (rst_n),
    .wb_regwrite   (w_regwrite),
    .wb_memtoreg   (w_memtoreg),
    .wb_read_data  (w_read_data),
    .wb_alu_result (w_alu_result),
    .wb_rd_addr    (w_rd_addr),
    .id_rs1_addr   (w_rs1_addr),
    .id_rs2_addr   (w_rs2_addr),
    .id_rs1_data   (w_rs1_data),
    .id_rs2_data   (w_rs2_data),
    .wb_write_data (w_write_data),
    .wb_write_en   (w_write_en),
    .commit_count  (w_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    regwrite     = 1'b0;
    memtoreg     = 1'b0;
    read_data    = 32'h0;
    alu_result   = 32'h0;
    rd_addr      = 5'd0;
    rs1_addr     = 5'd0;
    rs2_addr     = 5'd0;
    w_regwrite   = 1'b0;
    w_memtoreg   = 1'b0;
    w_read_data  = 32'h0;
    w_alu_result = 32'h0;
    w_rd_addr    = 5'd0;
    w_rs1_addr   = 5'd0;
    w_rs2_addr   = 5'd0;
  endtask

  // Power-on reset values, then an asynchronous reset in mid-run that must
  // clear x5 immediately and swallow the write presented alongside it.
  task automatic test_reset();
    rs1_addr = 5'd5;
    rs2_addr = 5'd31;
    #1;
    n_cmp++;
    if (rs1_data !== 32'h0) begin
      n_fail++;
      $display("[TB] FAIL reset_rs1: got %h expected %h", rs1_data, 32'h0);
    end
    n_cmp++;
    if (rs2_data !== 32'h0) begin
      n_fail++;
      $display("[TB] FAIL reset_rs2: got %h expected %h", rs2_data, 32'h0);
    end
    n_cmp++;
    if (commit_count !== 64'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_count: got %0d expected 0", commit_count);
    end
    n_cmp++;
    if (w_count !== 4'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_wcount: got %0d expected 0", w_count);
    end

    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    regwrite   = 1'b1;
    rd_addr    = 5'd5;
    alu_result = 32'hDEADBEEF;
    @(posedge clk);
    #1;
    regwrite = 1'b0;
    #1;
    n_cmp++;
    if (rs1_data !== 32'hDEADBEEF) begin
      n_fail++;
      $display("[TB] FAIL pre_reset_x5: got %h expected %h", rs1_data, 32'hDEADBEEF);
    end
    n_cmp++;
    if (commit_count !== 64'd1) begin
      n_fail++;
      $display("[TB] FAIL pre_reset_count: got %0d expected 1", commit_count);
    end

    @(negedge clk);
    regwrite   = 1'b1;
    rd_addr    = 5'd6;
    alu_result = 32'h0BADF00D;
    rs1_addr   = 5'd5;
    rs2_addr   = 5'd6;
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (rs1_data !== 32'h0) begin
      n_fail++;
      $display("[TB] FAIL midrun_reset_x5: got %h expected %h", rs1_data, 32'h0);
    end
    n_cmp++;
    if (commit_count !== 64'd0) begin
      n_fail++;
      $display("[TB] FAIL midrun_reset_count: got %0d expected 0", commit_count);
    end
    @(posedge clk);
    #1;
    regwrite = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (rs2_data !== 32'h0) begin
      n_fail++;
      $display("[TB] FAIL reset_lost_write_x6: got %h expected %h", rs2_data, 32'h0);
    end
    n_cmp++;
    if (commit_count !== 64'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_lost_write_count: got %0d expected 0", commit_count);
    end
  endtask

  // Load data then ALU result committed to x7.
  task automatic test_mux_commit();
    @(negedge clk);
    regwrite   = 1'b1;
    memtoreg   = 1'b1;
    read_data  = 32'h11112222;
    alu_result = 32'h33334444;
    rd_addr    = 5'd7;
    rs1_addr   = 5'd0;
    rs2_addr   = 5'd0;
    #1;
    n_cmp++;
    if (write_data !== 32'h11112222) begin
      n_fail++;
      $display("[TB] FAIL mux_load_data: got %h expected %h", write_data, 32'h11112222);
    end
    n_cmp++;
    if (write_en !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL mux_write_en: got %b expected 1", write_en);
    end
    @(posedge clk);
    #1;
    regwrite = 1'b0;
    rs2_addr = 5'd7;
    #1;
    n_cmp++;
    if (rs2_data !== 32'h11112222) begin
      n_fail++;
      $display("[TB] FAIL commit_load_x7: got %h expected %h", rs2_data, 32'h11112222);
    end
    n_cmp++;
    if (commit_count !== 64'd1) begin
      n_fail++;
      $display("[TB] FAIL commit_load_count: got %0d expected 1", commit_count);
    end

    @(negedge clk);
    regwrite = 1'b1;
    memtoreg = 1'b0;
    rs2_addr = 5'd0;
    @(posedge clk);
    #1;
    regwrite = 1'b0;
    rs2_addr = 5'd7;
    #1;
    n_cmp++;
    if (rs2_data !== 32'h33334444) begin
      n_fail++;
      $display("[TB] FAIL commit_alu_x7: got %h expected %h", rs2_data, 32'h33334444);
    end
    n_cmp++;
    if (commit_count !== 64'd2) begin
      n_fail++;
      $display("[TB] FAIL commit_alu_count: got %0d expected 2", commit_count);
    end
  endtask

  // Both read ports on the write target see the value before the edge.
  task automatic test_bypass();
    @(negedge clk);
    regwrite   = 1'b1;
    memtoreg   = 1'b0;
    alu_result = 32'hCAFEF00D;
    read_data  = 32'h55555555;
    rd_addr    = 5'd3;
    rs1_addr   = 5'd3;
    rs2_addr   = 5'd3;
    #1;
    n_cmp++;
    if (rs1_data !== 32'hCAFEF00D) begin
      n_fail++;
      $display("[TB] FAIL bypass_rs1: got %h expected %h", rs1_data, 32'hCAFEF00D);
    end
    n_cmp++;
    if (rs2_data !== 32'hCAFEF00D) begin
      n_fail++;
      $display("[TB] FAIL bypass_rs2: got %h expected %h", rs2_data, 32'hCAFEF00D);
    end
    @(posedge clk);
    #1;
    regwrite   = 1'b0;
    alu_result = 32'h0;
    #1;
    n_cmp++;
    if (rs1_data !== 32'hCAFEF00D) begin
      n_fail++;
      $display("[TB] FAIL bypass_stored_x3: got %h expected %h", rs1_data, 32'hCAFEF00D);
    end
    n_cmp++;
    if (commit_count !== 64'd3) begin
      n_fail++;
      $display("[TB] FAIL bypass_count: got %0d expected 3", commit_count);
    end
  endtask

  // A write aimed at x0 is not a commit and never becomes visible.
  task automatic test_x0();
    @(negedge clk);
    regwrite   = 1'b1;
    memtoreg   = 1'b0;
    alu_result = 32'hFFFFFFFF;
    rd_addr    = 5'd0;
    rs1_addr   = 5'd0;
    rs2_addr   = 5'd0;
    #1;
    n_cmp++;
    if (rs1_data !== 32'h0) begin
      n_fail++;
      $display("[TB] FAIL x0_bypass_rs1: got %h expected %h", rs1_data, 32'h0);
    end
    n_cmp++;
    if (write_en !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL x0_write_en: got %b expected 0", write_en);
    end
    @(posedge clk);
    #1;
    regwrite = 1'b0;
    #1;
    n_cmp++;
    if (rs1_data !== 32'h0) begin
      n_fail++;
      $display("[TB] FAIL x0_after_edge: got %h expected %h", rs1_data, 32'h0);
    end
    n_cmp++;
    if (commit_count !== 64'd3) begin
      n_fail++;
      $display("[TB] FAIL x0_count: got %0d expected 3", commit_count);
    end
  endtask

  // regwrite low: mux output still live, no state change, no bypass.
  task automatic test_gating();
    @(negedge clk);
    regwrite   = 1'b0;
    memtoreg   = 1'b0;
    alu_result = 32'h12345678;
    read_data  = 32'hA5A5A5A5;
    rd_addr    = 5'd9;
    rs1_addr   = 5'd9;
    rs2_addr   = 5'd0;
    #1;
    n_cmp++;
    if (write_data !== 32'h12345678) begin
      n_fail++;
      $display("[TB] FAIL gating_write_data: got %h expected %h", write_data, 32'h12345678);
    end
    n_cmp++;
    if (rs1_data !== 32'h0) begin
      n_fail++;
      $display("[TB] FAIL gating_no_bypass: got %h expected %h", rs1_data, 32'h0);
    end
    memtoreg = 1'b1;
    #1;
    n_cmp++;
    if (write_data !== 32'hA5A5A5A5) begin
      n_fail++;
      $display("[TB] FAIL gating_memtoreg_data: got %h expected %h", write_data, 32'hA5A5A5A5);
    end
    @(posedge clk);
    #2;
    n_cmp++;
    if (rs1_data !== 32'h0) begin
      n_fail++;
      $display("[TB] FAIL gating_x9: got %h expected %h", rs1_data, 32'h0);
    end
    n_cmp++;
    if (commit_count !== 64'd3) begin
      n_fail++;
      $display("[TB] FAIL gating_count: got %0d expected 3", commit_count);
    end
  endtask

  // Two consecutive commits; the second cycle reads the first from the
  // array and the second through the bypass.
  task automatic test_back_to_back();
    @(negedge clk);
    regwrite   = 1'b1;
    memtoreg   = 1'b0;
    alu_result = 32'h0000000A;
    rd_addr    = 5'd10;
    rs1_addr   = 5'd0;
    rs2_addr   = 5'd0;
    @(posedge clk);
    #1;
    alu_result = 32'h0000000B;
    rd_addr    = 5'd11;
    rs1_addr   = 5'd10;
    rs2_addr   = 5'd11;
    #1;
    n_cmp++;
    if (rs1_data !== 32'h0000000A) begin
      n_fail++;
      $display("[TB] FAIL b2b_rs1_x10: got %h expected %h", rs1_data, 32'h0000000A);
    end
    n_cmp++;
    if (rs2_data !== 32'h0000000B) begin
      n_fail++;
      $display("[TB] FAIL b2b_rs2_bypass_x11: got %h expected %h", rs2_data, 32'h0000000B);
    end
    @(posedge clk);
    #1;
    regwrite = 1'b0;
    #1;
    n_cmp++;
    if (rs2_data !== 32'h0000000B) begin
      n_fail++;
      $display("[TB] FAIL b2b_stored_x11: got %h expected %h", rs2_data, 32'h0000000B);
    end
    n_cmp++;
    if (commit_count !== 64'd5) begin
      n_fail++;
      $display("[TB] FAIL b2b_count: got %0d expected 5", commit_count);
    end
  endtask

  // 4-bit counter instance: 15 commits reach the top, the 16th wraps to 0.
  task automatic test_counter_wrap();
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      w_regwrite   = 1'b1;
      w_memtoreg   = 1'b0;
      w_alu_result = 32'(i + 1);
      w_rd_addr    = 5'd1;
    end
    @(posedge clk);
    #1;
    w_regwrite = 1'b0;
    #1;
    n_cmp++;
    if (w_count !== 4'hF) begin
      n_fail++;
      $display("[TB] FAIL wrap_count_top: got %0d expected 15", w_count);
    end
    @(negedge clk);
    w_regwrite   = 1'b1;
    w_alu_result = 32'h5A5A5A5A;
    w_rd_addr    = 5'd1;
    w_rs1_addr   = 5'd1;
    @(posedge clk);
    #1;
    w_regwrite = 1'b0;
    #1;
    n_cmp++;
    if (w_count !== 4'h0) begin
      n_fail++;
      $display("[TB] FAIL wrap_count_zero: got %0d expected 0", w_count);
    end
    n_cmp++;
    if (w_rs1_data !== 32'h5A5A5A5A) begin
      n_fail++;
      $display("[TB] FAIL wrap_x1: got %h expected %h", w_rs1_data, 32'h5A5A5A5A);
    end
    n_cmp++;
    if (commit_count !== 64'd5) begin
      n_fail++;
      $display("[TB] FAIL wrap_main_count: got %0d expected 5", commit_count);
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);

    test_reset();
    test_mux_commit();
    test_bypass();
    test_x0();
    test_gating();
    test_back_to_back();
    test_counter_wrap();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_wb_regfile
